// File: rtl/note_sequencer.sv
// Song ROM player: fetches note/duration words, plays them with
// a millisecond prescaler and a fixed silent gap after each note.
module note_sequencer #(
  parameter int ADDR_W = 8,
  parameter int GAP_MS = 10,
  parameter bit LOOP   = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              pause,
  input  logic [15:0]       ticks_per_milli,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic [3:0]        note,
  output logic              note_on,
  output logic [7:0]        led,
  output logic              done,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT_ROM, PLAY, GAP, DONE
  } state_t;

  localparam logic [15:0] GAP_LAST =
    16'((GAP_MS > 0) ? GAP_MS - 1 : 0);

  state_t      state;
  logic [15:0] pre_cnt;
  logic [15:0] gap_cnt;
  logic [11:0] dur_cnt;
  logic [15:0] tpm_eff;
  logic [3:0]  rom_code;
  logic [3:0]  code_m1;
  logic        run;
  logic        ms_tick;
  logic        gap_end;

  assign tpm_eff  = (ticks_per_milli == 16'd0) ? 16'd1
                                               : ticks_per_milli;
  assign rom_code = rom_data[15:12];
  assign code_m1  = rom_code - 4'd1;
  assign run      = !pause && (state == PLAY || state == GAP);
  // >= so a lowered ticks_per_milli cannot strand the counter
  assign ms_tick  = run && (pre_cnt >= tpm_eff - 16'd1);
  assign gap_end  = (GAP_MS == 0) ? 1'b1
                  : (ms_tick && gap_cnt == GAP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rom_addr <= '0;
      note     <= 4'd0;
      note_on  <= 1'b0;
      led      <= 8'h00;
      done     <= 1'b0;
      busy     <= 1'b0;
      pre_cnt  <= 16'd0;
      gap_cnt  <= 16'd0;
      dur_cnt  <= 12'd0;
    end else begin
      done <= 1'b0;
      if (run)
        pre_cnt <= ms_tick ? 16'd0 : pre_cnt + 16'd1;
      if (!pause) begin
        unique case (state)
          IDLE, DONE: begin
            if (start) begin
              state    <= FETCH;
              rom_addr <= '0;
              busy     <= 1'b1;
              led      <= 8'h00;
            end
          end
          FETCH: state <= WAIT_ROM;
          WAIT_ROM: begin
            if (rom_code == 4'hF) begin
              if (LOOP) begin
                state    <= FETCH;
                rom_addr <= '0;
              end else begin
                state <= DONE;
                done  <= 1'b1;
                busy  <= 1'b0;
                led   <= 8'hFF;
              end
            end else begin
              state   <= PLAY;
              pre_cnt <= 16'd0;
              dur_cnt <= rom_data[11:0];
              note    <= rom_code;
              note_on <= (rom_code != 4'd0);
              led     <= (rom_code != 4'd0)
                         ? (8'd1 << code_m1[2:0]) : 8'h00;
            end
          end
          PLAY: begin
            if (dur_cnt == 12'd0 ||
                (ms_tick && dur_cnt == 12'd1)) begin
              state   <= GAP;
              pre_cnt <= 16'd0;
              gap_cnt <= 16'd0;
              dur_cnt <= 12'd0;
              note    <= 4'd0;
              note_on <= 1'b0;
              led     <= 8'h00;
            end else if (ms_tick) begin
              dur_cnt <= dur_cnt - 12'd1;
            end
          end
          GAP: begin
            if (gap_end) begin
              state    <= FETCH;
              rom_addr <= rom_addr + ADDR_W'(1);
              gap_cnt  <= 16'd0;
            end else if (ms_tick) begin
              gap_cnt <= gap_cnt + 16'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/note_sequencer.md
NOTE_SEQUENCER -- requirements
Module: note_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8, width of the song ROM address.
REQ-002 Parameter GAP_MS, default 10, silent gap in ms inserted after every note.
REQ-003 Parameter LOOP, default 0, 1 = restart at address 0 after end-of-song.
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 start  input  1  level; sampled in IDLE/DONE, begins playback from address 0.
REQ-007 pause  input  1  level; while high, ms timing and state are frozen.
REQ-008 ticks_per_milli  input  16  clk cycles per millisecond; 0 treated as 1.
REQ-009 rom_addr  output  ADDR_W  song ROM address.
REQ-010 rom_data  input  16  ROM word, valid exactly 1 cycle after rom_addr changes: [15:12] note code, [11:0] duration ms.
REQ-011 note  output  4  current note code to tone generator; 0 when silent.
REQ-012 note_on  output  1  high while a non-rest note is playing.
REQ-013 led  output  8  activity display.
REQ-014 done  output  1  one-cycle pulse at end of song.
REQ-015 busy  output  1  high in every state except IDLE and DONE.

Function
REQ-016 States: IDLE, FETCH, WAIT_ROM, PLAY, GAP, DONE.
REQ-017 Ms prescaler: counter 0..max(ticks_per_milli,1)-1, ms_tick one cycle at terminal count, counter wraps to 0; runs only in PLAY/GAP with pause low; cleared on entry to PLAY and GAP.
REQ-018 IDLE: start high -> FETCH, rom_addr := 0.
REQ-019 FETCH: one cycle, presents rom_addr -> WAIT_ROM.
REQ-020 WAIT_ROM: latch rom_data; code 15 = end-of-song -> DONE (LOOP=0) or FETCH with rom_addr := 0 (LOOP=1); otherwise -> PLAY, load duration counter.
REQ-021 Duration 0 on a non-end entry: PLAY lasts 0 ms, proceeds directly to GAP next cycle.
REQ-022 PLAY: note := latched code; note_on := (code != 0); code 0 = rest, note 0, note_on 0.
REQ-023 PLAY: duration counter decrements on ms_tick; on ms_tick with counter = 1 -> GAP.
REQ-024 GAP: note 0, note_on 0; after GAP_MS ms_ticks (GAP_MS = 0: one cycle) -> FETCH, rom_addr := rom_addr + 1.
REQ-025 rom_addr wraps modulo 2^ADDR_W without end marker; no error flagged.
REQ-026 DONE: done pulses on entry cycle only; start high -> FETCH from address 0; start held high continuously from DONE restarts.
REQ-027 pause high: prescaler, duration and gap counters hold; state holds; note/note_on hold; pause has no effect in IDLE/DONE/FETCH/WAIT_ROM except freezing the state.
REQ-028 start while busy: ignored.
REQ-029 led: PLAY with note_on -> one-hot bit (note-1) mod 8; rest/GAP/FETCH/WAIT_ROM -> 8'h00; IDLE -> 8'h00; DONE -> 8'hFF.
REQ-030 ticks_per_milli change mid-note: takes effect at next prescaler wrap comparison; no glitch in state.
REQ-031 All outputs registered.

Reset
REQ-032 rst high: state IDLE, rom_addr 0, note 0, note_on 0, led 8'h00, done 0, busy 0, all counters 0, immediately and independent of clk.
REQ-033 rst asserted mid-note: playback aborts; after release, idle until start.

Verification
REQ-034 ticks_per_milli=4, ROM {0x1003, 0xF000}, start pulse -> note=1/note_on=1 for 12 cycles, gap 40 cycles (GAP_MS=10), done pulse once, led 8'hFF.
REQ-035 ticks_per_milli=0, ROM {0x0002, 0xF000} -> rest: note_on 0 for 2 cycles, then gap, done.
REQ-036 LOOP=1, ROM {0x2001, 0xF000} -> note 2 repeats indefinitely, done never pulses.
REQ-037 pause high 50 cycles mid-PLAY -> note duration extended by exactly 50 cycles.
REQ-038 rst asserted during PLAY -> outputs reset same cycle asynchronously; start after release replays from address 0.
REQ-039 start held high during PLAY -> no restart; rom_addr sequence 0,1,2 unaffected.
